// File: rtl/decode_queue_if.sv
// Decode-to-issue handshake bundle: enqueue lanes from decode, dequeue window to the consumer.
// Storage-side status (count/empty/full) stays on the queue's own ports.
interface decode_queue_if #(
    parameter int unsigned ENQ_W  = 2,
    parameter int unsigned DEQ_W  = 2,
    parameter int unsigned ITEM_W = 50
);
    localparam int unsigned DCW = $clog2(DEQ_W + 1);

    logic [ENQ_W-1:0]             enq_valid;
    logic [ENQ_W-1:0][ITEM_W-1:0] enq_item;
    logic                         enq_ready;
    logic [DEQ_W-1:0]             deq_valid;
    logic [DEQ_W-1:0][ITEM_W-1:0] deq_item;
    logic [DCW-1:0]               deq_count;

    modport master (
        output enq_valid, enq_item, deq_count,
        input  enq_ready, deq_valid, deq_item
    );

    modport slave (
        input  enq_valid, enq_item, deq_count,
        output enq_ready, deq_valid, deq_item
    );
endinterface

// File: rtl/decode_queue.sv
// Multi-lane circular FIFO holding opaque micro-ops between decode and issue.
// All outputs come from registered pointers/occupancy plus the storage read mux.
module decode_queue #(
    parameter int unsigned ENQ_W  = 2,
    parameter int unsigned DEQ_W  = 2,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ITEM_W = 50,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    decode_queue_if.slave q,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [ITEM_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [ENQ_W-1:0]  acc_mask;
    logic [CW-1:0]     n_enq;
    logic [CW-1:0]     n_deq;
    logic [CW-1:0]     deq_req;
    logic [CW-1:0]     enq_add;
    logic              ready;
    logic              enq_fire;
    logic              run;

    // Accepted lanes are the unbroken run of valids starting at lane 0.
    always_comb begin
        acc_mask = '0;
        n_enq    = '0;
        run      = 1'b1;
        for (int unsigned k = 0; k < ENQ_W; k++) begin
            if (run && q.enq_valid[k]) begin
                acc_mask[k] = 1'b1;
                n_enq       = n_enq + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign ready    = (CW'(DEPTH) - count) >= CW'(ENQ_W);
    assign enq_fire = ready && (n_enq != '0);
    assign enq_add  = enq_fire ? n_enq : '0;
    assign deq_req  = CW'(q.deq_count);
    assign n_deq    = (deq_req > count) ? count : deq_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_deq);
            tail  <= tail + PW'(enq_add);
            count <= count + enq_add - n_deq;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire && !flush && !rst) begin
            for (int unsigned k = 0; k < ENQ_W; k++) begin
                if (acc_mask[k]) begin
                    mem[tail + PW'(k)] <= q.enq_item[k];
                end
            end
        end
    end

    always_comb begin
        q.deq_valid = '0;
        q.deq_item  = '0;
        for (int unsigned i = 0; i < DEQ_W; i++) begin
            q.deq_valid[i] = count > CW'(i);
            q.deq_item[i]  = mem[head + PW'(i)];
        end
    end

    assign q.enq_ready = ready;
    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: table-driven occupancy/ready vectors, an item
// scoreboard for dequeue contents, a pointer-wrap ordering run and an async-reset check.
module tb_decode_queue;
    localparam int unsigned ENQ_W  = 2;
    localparam int unsigned DEQ_W  = 2;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ITEM_W = 50;

    typedef struct {
        logic       fl;
        logic [1:0] ev;
        logic [1:0] dc;
        int         exp_count;
        logic       exp_ready;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [3:0] count;
    logic       empty;
    logic       full;

    int n_cmp;
    int n_bad;
    int tag;
    logic [ITEM_W-1:0] sb [$];
    logic [31:0]       got [$];
    vec_t              tbl [24];

    decode_queue_if #(.ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .ITEM_W(ITEM_W)) qif ();

    decode_queue #(.ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DEPTH(DEPTH), .ITEM_W(ITEM_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .q     (qif),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ITEM_W-1:0] mk(input int t);
        logic [17:0] hi;
        hi = 18'(t * 7 + 18'h2A5A5);
        return {hi, 32'(t)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: compare the dequeue window against the scoreboard, drive, clock, update model.
    task automatic cycle(input logic fl, input logic [1:0] ev, input logic [1:0] dc, input bit capture);
        int nd;
        int na;
        int sz;
        logic [DEQ_W-1:0] exp_v;
        sz = sb.size();
        exp_v = '0;
        for (int i = 0; i < int'(DEQ_W); i++) begin
            exp_v[i] = (sz > i);
            if (sz > i) check($sformatf("deq_item[%0d]", i), 64'(qif.deq_item[i]), 64'(sb[i]));
        end
        check("deq_valid", 64'(qif.deq_valid), 64'(exp_v));
        nd = (int'(dc) < sz) ? int'(dc) : sz;
        if (capture) for (int j = 0; j < nd; j++) got.push_back(qif.deq_item[j][31:0]);
        na = 0;
        if ((int'(DEPTH) - sz) >= int'(ENQ_W)) begin
            if (ev[0]) begin
                na = 1;
                if (ev[1]) na = 2;
            end
        end
        flush = fl;
        qif.enq_valid = ev;
        qif.enq_item[0] = mk(tag);
        qif.enq_item[1] = mk(tag + 1);
        qif.deq_count = dc;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            for (int j = 0; j < nd; j++) void'(sb.pop_front());
            for (int j = 0; j < na; j++) sb.push_back(mk(tag + j));
        end
        tag += 2;
        flush = 1'b0;
        qif.enq_valid = '0;
        qif.deq_count = '0;
        check("model_count", 64'(count), 64'(sb.size()));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tag = 0;
        rst = 1'b1;
        flush = 1'b0;
        qif.enq_valid = '0;
        qif.enq_item = '0;
        qif.deq_count = '0;

        // fill, ready drop at 7, non-contiguous valid, over-dequeue, flush, full
        tbl[0]  = '{1'b0, 2'b11, 2'd0, 2, 1'b1};
        tbl[1]  = '{1'b0, 2'b11, 2'd0, 4, 1'b1};
        tbl[2]  = '{1'b0, 2'b11, 2'd0, 6, 1'b1};
        tbl[3]  = '{1'b0, 2'b01, 2'd0, 7, 1'b0};
        tbl[4]  = '{1'b0, 2'b11, 2'd0, 7, 1'b0};
        tbl[5]  = '{1'b0, 2'b00, 2'd1, 6, 1'b1};
        tbl[6]  = '{1'b0, 2'b10, 2'd0, 6, 1'b1};
        tbl[7]  = '{1'b0, 2'b01, 2'd0, 7, 1'b0};
        tbl[8]  = '{1'b0, 2'b00, 2'd2, 5, 1'b1};
        tbl[9]  = '{1'b0, 2'b00, 2'd2, 3, 1'b1};
        tbl[10] = '{1'b0, 2'b00, 2'd2, 1, 1'b1};
        tbl[11] = '{1'b0, 2'b00, 2'd2, 0, 1'b1};
        tbl[12] = '{1'b0, 2'b11, 2'd0, 2, 1'b1};
        tbl[13] = '{1'b0, 2'b11, 2'd0, 4, 1'b1};
        tbl[14] = '{1'b0, 2'b01, 2'd0, 5, 1'b1};
        tbl[15] = '{1'b1, 2'b11, 2'd2, 0, 1'b1};
        tbl[16] = '{1'b0, 2'b11, 2'd0, 2, 1'b1};
        tbl[17] = '{1'b0, 2'b00, 2'd2, 0, 1'b1};
        tbl[18] = '{1'b0, 2'b11, 2'd0, 2, 1'b1};
        tbl[19] = '{1'b0, 2'b11, 2'd0, 4, 1'b1};
        tbl[20] = '{1'b0, 2'b11, 2'd0, 6, 1'b1};
        tbl[21] = '{1'b0, 2'b11, 2'd0, 8, 1'b0};
        tbl[22] = '{1'b0, 2'b11, 2'd2, 6, 1'b1};
        tbl[23] = '{1'b0, 2'b11, 2'd2, 6, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_ready", 64'(qif.enq_ready), 64'd1);
        check("rst_deq_valid", 64'(qif.deq_valid), 64'd0);

        for (int r = 0; r < 24; r++) begin
            cycle(tbl[r].fl, tbl[r].ev, tbl[r].dc, 1'b0);
            check($sformatf("row%0d_count", r), 64'(count), 64'(tbl[r].exp_count));
            check($sformatf("row%0d_ready", r), 64'(qif.enq_ready), 64'(tbl[r].exp_ready));
            check($sformatf("row%0d_empty", r), 64'(empty), 64'(tbl[r].exp_count == 0));
            check($sformatf("row%0d_full", r), 64'(full), 64'(tbl[r].exp_count == 8));
        end

        // pointer wrap: tags 0..39 must come out in order
        cycle(1'b1, 2'b00, 2'd0, 1'b0);
        tag = 0;
        got.delete();
        for (int c = 0; c < 20; c++) cycle(1'b0, 2'b11, 2'd2, 1'b1);
        for (int c = 0; c < 2; c++) cycle(1'b0, 2'b00, 2'd2, 1'b1);
        check("wrap_len", 64'(got.size()), 64'd40);
        for (int j = 0; j < got.size(); j++) check($sformatf("wrap_tag%0d", j), 64'(got[j]), 64'(j));
        check("wrap_empty", 64'(empty), 64'd1);

        // async reset between edges at count 6
        for (int c = 0; c < 3; c++) cycle(1'b0, 2'b11, 2'd0, 1'b0);
        check("pre_rst_count", 64'(count), 64'd6);
        #3;
        rst = 1'b1;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_empty", 64'(empty), 64'd1);
        check("arst_full", 64'(full), 64'd0);
        check("arst_ready", 64'(qif.enq_ready), 64'd1);
        check("arst_deq_valid", 64'(qif.deq_valid), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b0, 2'b11, 2'd0, 1'b0);
        cycle(1'b0, 2'b00, 2'd1, 1'b0);
        check("post_rst_count", 64'(count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
